// File: rtl/riscv_test_monitor.sv
// Drives the core reset and watches the data-memory write port for tohost writes.
// Reports pass / fail (with test number) / timeout as sticky registered status.
module riscv_test_monitor #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_1000),
    parameter int              TIMEOUT     = 5000,
    parameter int              RST_CYCLES  = 1,
    parameter int              CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [XLEN-1:0]   wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [XLEN/8-1:0] wr_strb,
    output logic              core_rst,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [XLEN-2:0]   fail_code,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic            wr_hit;

    // Only full-word writes to tohost count; partial strobes are ignored.
    assign wr_hit = wr_valid && (wr_addr == TOHOST_ADDR) && (&wr_strb);

    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN: begin
                // An odd tohost write beats a same-cycle timeout.
                if (wr_hit && wr_data[0])
                    state_nxt = (wr_data == XLEN'(1)) ? S_PASS : S_FAIL;
                else if ((TIMEOUT != 0) && (cycle_count == TMO_LAST))
                    state_nxt = S_TMO;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            cycle_count <= '0;
            fail_code   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_HOLD)
                hold_cnt <= hold_cnt + 1'b1;
            if (state == S_RUN && !(&cycle_count))
                cycle_count <= cycle_count + 1'b1;
            if (state == S_RUN && state_nxt == S_FAIL)
                fail_code <= wr_data[XLEN-1:1];
        end
    end

    assign core_rst = (state == S_HOLD);
    assign pass     = (state == S_PASS);
    assign fail     = (state == S_FAIL);
    assign timeout  = (state == S_TMO);
    assign done     = pass | fail | timeout;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: three configurations share one write bus and reset,
// and are checked against an event-level model (first odd tohost write or timeout).
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;

    logic [2:0]  core_rst_w, done_w, pass_w, fail_w, tmo_w;
    logic [30:0] fc_w [3];
    logic [31:0] cc_a, cc_b;
    logic [3:0]  cc_c;

    int checks = 0;
    int errors = 0;

    // Config table: A = (RST 3, TIMEOUT 50), B = (RST 1, TIMEOUT 10), C = (RST 2, no timeout, 4-bit count)
    int    RSTC [3] = '{3, 1, 2};
    int    TMOC [3] = '{50, 10, 0};
    longint CMAX [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};

    always #5 clk = ~clk;

    riscv_test_monitor #(.XLEN(32), .TOHOST_ADDR(32'h1000), .TIMEOUT(50), .RST_CYCLES(3), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .core_rst(core_rst_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .timeout(tmo_w[0]),
        .fail_code(fc_w[0]), .cycle_count(cc_a));
    riscv_test_monitor #(.XLEN(32), .TOHOST_ADDR(32'h1000), .TIMEOUT(10), .RST_CYCLES(1), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .core_rst(core_rst_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .timeout(tmo_w[1]),
        .fail_code(fc_w[1]), .cycle_count(cc_b));
    riscv_test_monitor #(.XLEN(32), .TOHOST_ADDR(32'h1000), .TIMEOUT(0), .RST_CYCLES(2), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .core_rst(core_rst_w[2]), .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .timeout(tmo_w[2]),
        .fail_code(fc_w[2]), .cycle_count(cc_c));

    logic [4:0]  obs_stat [3];
    logic [31:0] obs_cc   [3];
    always_comb begin
        for (int d = 0; d < 3; d++)
            obs_stat[d] = {core_rst_w[d], done_w[d], pass_w[d], fail_w[d], tmo_w[d]};
        obs_cc[0] = cc_a;
        obs_cc[1] = cc_b;
        obs_cc[2] = {28'b0, cc_c};
    end

    // Reference model: k = clock edges since reset release; each config records the
    // run index of its first verdict event and what kind it was (1 pass, 2 fail, 3 timeout).
    int          k;
    int          vr    [3];
    int          vtype [3];
    logic [31:0] vdata [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0;
            for (int d = 0; d < 3; d++) begin vr[d] = -1; vtype[d] = 0; vdata[d] = 0; end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (vr[d] < 0 && k >= RSTC[d]) begin
                    if (wr_valid && wr_addr == 32'h1000 && wr_strb == 4'hF && wr_data[0]) begin
                        vr[d] = k - RSTC[d];
                        vtype[d] = (wr_data == 32'd1) ? 1 : 2;
                        vdata[d] = wr_data;
                    end else if (TMOC[d] != 0 && k - RSTC[d] == TMOC[d] - 1) begin
                        vr[d] = k - RSTC[d];
                        vtype[d] = 3;
                    end
                end
            end
            k = k + 1;
        end
    end

    function automatic logic [4:0] exp_stat(int d);
        return {k < RSTC[d], vtype[d] != 0, vtype[d] == 1, vtype[d] == 2, vtype[d] == 3};
    endfunction

    function automatic logic [31:0] exp_cc(int d);
        longint n;
        if (vr[d] >= 0)      n = vr[d] + 1;
        else if (k > RSTC[d]) n = k - RSTC[d];
        else                 n = 0;
        if (n > CMAX[d]) n = CMAX[d];
        return n[31:0];
    endfunction

    function automatic logic [30:0] exp_fc(int d);
        logic [31:0] v;
        v = (vtype[d] == 2) ? vdata[d] : 32'd0;
        return v[31:1];
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s);
        wr_valid = v; wr_addr = a; wr_data = dat; wr_strb = s;
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_k(input int target, input string name);
        for (int i = 0; i < 20000 && k < target; i++) @(negedge clk);
        checks++;
        if (k != target) begin
            errors++;
            $display("FAIL %s_wait k=%0d want %0d", name, k, target);
        end
    endtask

    task automatic test_reset;
        do_reset(2);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_stat[d] !== 5'b10000 || obs_cc[d] !== 32'd0 || fc_w[d] !== 31'd0) begin
                errors++;
                $display("FAIL reset_vals dut%0d stat=%b cc=%0d fc=%0d want 10000/0/0", d, obs_stat[d], obs_cc[d], fc_w[d]);
            end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs_stat[d] !== exp_stat(d) || obs_cc[d] !== exp_cc(d)) begin
                    errors++;
                    $display("FAIL reset_seq dut%0d k=%0d stat=%b cc=%0d want %b/%0d", d, k, obs_stat[d], obs_cc[d], exp_stat(d), exp_cc(d));
                end
            end
        end
        // k=6: config A left HOLD on edge 3 and has counted edges 4..6
        checks++;
        if (core_rst_w[0] !== 1'b0 || cc_a !== 32'd3) begin
            errors++;
            $display("FAIL reset_runA core_rst=%b cc=%0d want 0/3", core_rst_w[0], cc_a);
        end
    endtask

    task automatic test_pass;
        do_reset(2);
        wait_k(22, "pass");
        drive(1'b1, 32'h1000, 32'd1, 4'hF);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (pass_w[0] !== 1'b1 || done_w[0] !== 1'b1 || cc_a !== 32'd20 || obs_stat[0] !== exp_stat(0)) begin
            errors++;
            $display("FAIL pass_verdict pass=%b done=%b cc=%0d want 1/1/20", pass_w[0], done_w[0], cc_a);
        end
        repeat (3) @(negedge clk);
        drive(1'b1, 32'h1000, 32'd5, 4'hF);
        repeat (3) @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (fail_w[0] !== 1'b0 || pass_w[0] !== 1'b1 || cc_a !== 32'd20) begin
            errors++;
            $display("FAIL pass_sticky fail=%b pass=%b cc=%0d want 0/1/20", fail_w[0], pass_w[0], cc_a);
        end
    endtask

    task automatic test_fail_code;
        do_reset(1);
        wait_k(8, "fail");
        drive(1'b1, 32'h1000, 32'h0000_000B, 4'hF);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (fail_w[d] !== 1'b1 || pass_w[d] !== 1'b0 || fc_w[d] !== 31'd5 || fc_w[d] !== exp_fc(d)) begin
                errors++;
                $display("FAIL fail_code dut%0d fail=%b pass=%b code=%0d want 1/0/5", d, fail_w[d], pass_w[d], fc_w[d]);
            end
        end
    endtask

    task automatic test_ignored;
        do_reset(2);
        wait_k(5, "ign");
        drive(1'b1, 32'h1000, 32'd2, 4'hF);
        @(negedge clk);
        drive(1'b1, 32'h1004, 32'd1, 4'hF);
        @(negedge clk);
        drive(1'b1, 32'h1000, 32'd1, 4'h3);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        wait_k(52, "ign");
        checks++;
        if (done_w[0] !== 1'b0 || cc_a !== 32'd49) begin
            errors++;
            $display("FAIL ign_before done=%b cc=%0d want 0/49", done_w[0], cc_a);
        end
        @(negedge clk);
        checks++;
        if (tmo_w[0] !== 1'b1 || pass_w[0] !== 1'b0 || cc_a !== 32'd50 || obs_stat[0] !== exp_stat(0)) begin
            errors++;
            $display("FAIL ign_timeout tmo=%b pass=%b cc=%0d want 1/0/50", tmo_w[0], pass_w[0], cc_a);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (cc_a !== 32'd50 || core_rst_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL ign_frozen cc=%0d core_rst=%b want 50/0", cc_a, core_rst_w[0]);
        end
    endtask

    task automatic test_tie;
        do_reset(2);
        wait_k(10, "tie");
        checks++;
        if (cc_b !== 32'd9) begin
            errors++;
            $display("FAIL tie_pre cc=%0d want 9", cc_b);
        end
        drive(1'b1, 32'h1000, 32'd1, 4'hF);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (pass_w[1] !== 1'b1 || tmo_w[1] !== 1'b0 || cc_b !== 32'd10 || obs_stat[1] !== exp_stat(1)) begin
            errors++;
            $display("FAIL tie_verdict pass=%b tmo=%b cc=%0d want 1/0/10", pass_w[1], tmo_w[1], cc_b);
        end
    endtask

    task automatic test_no_timeout;
        do_reset(2);
        repeat (10000) @(negedge clk);
        checks++;
        if (done_w[2] !== 1'b0 || cc_c !== 4'hF || obs_cc[2] !== exp_cc(2)) begin
            errors++;
            $display("FAIL no_timeout done=%b cc=%0d want 0/15", done_w[2], cc_c);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            do_reset(1 + r % 2);
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (obs_stat[d] !== exp_stat(d) || obs_cc[d] !== exp_cc(d) || fc_w[d] !== exp_fc(d)) begin
                        errors++;
                        $display("FAIL random r%0d dut%0d k=%0d stat=%b cc=%0d fc=%0d want %b/%0d/%0d",
                                 r, d, k, obs_stat[d], obs_cc[d], fc_w[d], exp_stat(d), exp_cc(d), exp_fc(d));
                    end
                end
                if ($urandom_range(0, 9) == 0) begin
                    logic [31:0] dv;
                    case ($urandom_range(0, 2))
                        0:       dv = 32'd1;
                        1:       dv = $urandom | 32'd1;
                        default: dv = $urandom & ~32'd1;
                    endcase
                    drive(1'b1, ($urandom_range(0, 3) == 0) ? 32'h1004 : 32'h1000, dv,
                          ($urandom_range(0, 3) == 0) ? 4'h3 : 4'hF);
                end else begin
                    drive(1'b0, $urandom, $urandom, 4'hF);
                end
            end
            drive(1'b0, 32'h0, 32'h0, 4'h0);
        end
    endtask

    task automatic test_async_reset;
        do_reset(1);
        wait_k(15, "async");
        drive(1'b1, 32'h1000, 32'd1, 4'hF);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_stat[d] !== 5'b10000 || obs_cc[d] !== 32'd0 || obs_stat[d] !== exp_stat(d)) begin
                errors++;
                $display("FAIL async_rst dut%0d stat=%b cc=%0d want 10000/0", d, obs_stat[d], obs_cc[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (core_rst_w[0] !== 1'b0 || cc_a !== 32'd1 || done_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_rerun core_rst=%b cc=%0d done=%b want 0/1/0", core_rst_w[0], cc_a, done_w[0]);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_code();
        test_ignored();
        test_tie();
        test_no_timeout();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
